// File: rtl/sram_wr_ctrl_if.sv
// Memory write port between sram_wr_ctrl and the SRAM/BRAM port arbiter.
//   mem_we    : write valid (controller -> arbiter)
//   mem_addr  : linear frame-buffer word address
//   mem_wdata : RGB565 write data
//   mem_ready : arbiter accepts the beat when mem_we & mem_ready
interface sram_wr_ctrl_if #(
  parameter int unsigned P_ADDR_W = 17
);
  logic                mem_we;
  logic [P_ADDR_W-1:0] mem_addr;
  logic [15:0]         mem_wdata;
  logic                mem_ready;

  modport master (output mem_we, mem_addr, mem_wdata, input mem_ready);
  modport slave  (input mem_we, mem_addr, mem_wdata, output mem_ready);
endinterface

// File: rtl/sram_wr_ctrl.sv
// Frame-buffer write controller sitting behind the SPI command decoder.
// Tracks the draw-window cursor, converts pushed pixels into linear
// addresses, buffers them in a 2-entry FIFO plus a registered output stage,
// and runs a full-frame zero-fill sweep on a clear request.
//   i_clk, i_rst_n        : clock, asynchronous active-low reset
//   i_col_addr            : XS [31:16], XE [15:0]
//   i_row_addr            : YS [31:16], YE [15:0]
//   i_pixel_data          : RGB565 pixel, valid with i_sram_write_req
//   i_sram_write_req      : push one pixel (pulse)
//   i_sram_waddr_set_req  : latch window and home cursor (pulse)
//   i_sram_clr_req        : clear whole frame (pulse)
//   mem                   : valid/ready write port toward the arbiter
//   o_busy                : clear running, FIFO non-empty or write pending
//   o_overflow            : 1-cycle pulse when a pixel is dropped
module sram_wr_ctrl #(
  parameter int unsigned P_WIDTH  = 320,
  parameter int unsigned P_HEIGHT = 240,
  parameter int unsigned P_ADDR_W = 17
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [31:0]           i_col_addr,
  input  logic [31:0]           i_row_addr,
  input  logic [15:0]           i_pixel_data,
  input  logic                  i_sram_write_req,
  input  logic                  i_sram_waddr_set_req,
  input  logic                  i_sram_clr_req,
  sram_wr_ctrl_if.master        mem,
  output logic                  o_busy,
  output logic                  o_overflow
);

  localparam int unsigned         FRAME_PIX = P_WIDTH * P_HEIGHT;
  localparam logic [P_ADDR_W-1:0] CLR_LAST  = P_ADDR_W'(FRAME_PIX - 1);
  localparam logic [15:0]         XE_FULL   = 16'(P_WIDTH - 1);
  localparam logic [15:0]         YE_FULL   = 16'(P_HEIGHT - 1);

  typedef enum logic {ST_IDLE, ST_CLEAR} state_t;
  state_t state, state_nxt;

  logic [15:0] xs, xe, ys, ye, x, y;
  logic [15:0] set_xs, set_xe, set_ys, set_ye;
  logic [15:0] eff_xs, eff_xe, eff_ys, eff_ye, eff_x, eff_y;
  logic [15:0] x_nxt, y_nxt;
  logic        in_frame;
  logic [P_ADDR_W-1:0] push_addr;

  logic [P_ADDR_W-1:0] fifo_addr [2];
  logic [15:0]         fifo_data [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count;

  logic                out_we;
  logic [P_ADDR_W-1:0] out_addr;
  logic [15:0]         out_data;

  logic [P_ADDR_W-1:0] clr_cnt;
  logic                overflow;

  logic load_out, pop, push, bypass, fifo_wr, drop;

  // A window set in the same cycle as a push takes effect first, so the
  // cursor math below works on these "effective" values.
  always_comb begin
    set_xs = i_col_addr[31:16];
    set_xe = (i_col_addr[31:16] > i_col_addr[15:0]) ? i_col_addr[31:16] : i_col_addr[15:0];
    set_ys = i_row_addr[31:16];
    set_ye = (i_row_addr[31:16] > i_row_addr[15:0]) ? i_row_addr[31:16] : i_row_addr[15:0];
    eff_xs = i_sram_waddr_set_req ? set_xs : xs;
    eff_xe = i_sram_waddr_set_req ? set_xe : xe;
    eff_ys = i_sram_waddr_set_req ? set_ys : ys;
    eff_ye = i_sram_waddr_set_req ? set_ye : ye;
    eff_x  = i_sram_waddr_set_req ? set_xs : x;
    eff_y  = i_sram_waddr_set_req ? set_ys : y;
    in_frame  = (32'(eff_x) < P_WIDTH) && (32'(eff_y) < P_HEIGHT);
    push_addr = P_ADDR_W'(32'(eff_y) * P_WIDTH + 32'(eff_x));
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    drop      = 1'b0;
    x_nxt     = eff_x;
    y_nxt     = eff_y;
    load_out  = (state == ST_IDLE) && (!out_we || mem.mem_ready);
    pop       = load_out && (count != 2'd0);
    case (state)
      ST_IDLE: begin
        if (i_sram_clr_req) begin
          state_nxt = ST_CLEAR;
        end else if (i_sram_write_req) begin
          if (eff_x == eff_xe) begin
            x_nxt = eff_xs;
            y_nxt = (eff_y == eff_ye) ? eff_ys : eff_y + 16'd1;
          end else begin
            x_nxt = eff_x + 16'd1;
          end
          // A full FIFO can still take the pixel if its head leaves this cycle.
          if (in_frame) begin
            if (count == 2'd2 && !pop) drop = 1'b1;
            else                       push = 1'b1;
          end
        end
      end
      ST_CLEAR: begin
        if (!i_sram_clr_req) begin
          if (i_sram_write_req) drop = 1'b1;
          if (mem.mem_ready && clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Empty FIFO and a free output stage: skip the FIFO for 1-cycle latency.
    bypass  = push && (count == 2'd0) && load_out;
    fifo_wr = push && !bypass;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      xs       <= '0;
      xe       <= XE_FULL;
      ys       <= '0;
      ye       <= YE_FULL;
      x        <= '0;
      y        <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= '0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= '0;
      clr_cnt  <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop;
      if (i_sram_clr_req) begin
        xs      <= '0;
        xe      <= XE_FULL;
        ys      <= '0;
        ye      <= YE_FULL;
        x       <= '0;
        y       <= '0;
        wr_ptr  <= 1'b0;
        rd_ptr  <= 1'b0;
        count   <= '0;
        out_we  <= 1'b0;
        clr_cnt <= '0;
      end else begin
        xs <= eff_xs;
        xe <= eff_xe;
        ys <= eff_ys;
        ye <= eff_ye;
        x  <= x_nxt;
        y  <= y_nxt;
        if (fifo_wr) wr_ptr <= ~wr_ptr;
        if (pop)     rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, fifo_wr} - {1'b0, pop};
        if (load_out) begin
          if (pop) begin
            out_we   <= 1'b1;
            out_addr <= fifo_addr[rd_ptr];
            out_data <= fifo_data[rd_ptr];
          end else if (bypass) begin
            out_we   <= 1'b1;
            out_addr <= push_addr;
            out_data <= i_pixel_data;
          end else begin
            out_we   <= 1'b0;
          end
        end
        if (state == ST_CLEAR && mem.mem_ready) clr_cnt <= clr_cnt + P_ADDR_W'(1);
      end
    end
  end

  // FIFO storage needs no reset; occupancy is tracked by count/pointers.
  always_ff @(posedge i_clk) begin
    if (fifo_wr && !i_sram_clr_req) begin
      fifo_addr[wr_ptr] <= push_addr;
      fifo_data[wr_ptr] <= i_pixel_data;
    end
  end

  // The clear sweep drives the port directly from the counter; the pixel
  // output stage is flushed and idle for the whole sweep.
  always_comb begin
    mem.mem_we    = (state == ST_CLEAR) || out_we;
    mem.mem_addr  = (state == ST_CLEAR) ? clr_cnt : out_addr;
    mem.mem_wdata = (state == ST_CLEAR) ? '0 : out_data;
  end

  assign o_busy     = (state == ST_CLEAR) || (count != 2'd0) || mem.mem_we;
  assign o_overflow = overflow;

endmodule

// File: tb/tb_sram_wr_ctrl.sv
// Directed bench for sram_wr_ctrl: table of per-cycle vectors for window,
// push, discard and stall behaviour, plus hand sequences for the clear sweep,
// clear interaction and asynchronous reset.
module tb_sram_wr_ctrl;

  logic        clk;
  logic        rst_n;
  logic [31:0] col_addr, row_addr;
  logic [15:0] pixel_data;
  logic        write_req, waddr_set_req, clr_req;
  logic        busy, overflow;

  int checks = 0;
  int errors = 0;

  sram_wr_ctrl_if #(.P_ADDR_W(17)) bus();

  sram_wr_ctrl #(
    .P_WIDTH (320),
    .P_HEIGHT(240),
    .P_ADDR_W(17)
  ) dut (
    .i_clk               (clk),
    .i_rst_n             (rst_n),
    .i_col_addr          (col_addr),
    .i_row_addr          (row_addr),
    .i_pixel_data        (pixel_data),
    .i_sram_write_req    (write_req),
    .i_sram_waddr_set_req(waddr_set_req),
    .i_sram_clr_req      (clr_req),
    .mem                 (bus.master),
    .o_busy              (busy),
    .o_overflow          (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        set;
    logic [15:0] xs, xe, ys, ye;
    logic        wr;
    logic [15:0] pix;
    logic        rdy;
    logic        we;
    logic [31:0] addr;
    logic [15:0] data;
    logic        ovf;
    logic        bsy;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic set, input logic [15:0] xs, xe, ys, ye,
                              input logic wr, input logic [15:0] pix, input logic rdy,
                              input logic we, input int addr, input logic [15:0] data,
                              input logic ovf, input logic bsy);
    vec_t v;
    v.set = set; v.xs = xs; v.xe = xe; v.ys = ys; v.ye = ye;
    v.wr = wr; v.pix = pix; v.rdy = rdy;
    v.we = we; v.addr = 32'(addr); v.data = data; v.ovf = ovf; v.bsy = bsy;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    waddr_set_req = 1'b0;
    write_req     = 1'b0;
    clr_req       = 1'b0;
    pixel_data    = '0;
    col_addr      = '0;
    row_addr      = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int bad;
    int first_bad;

    rst_n = 1'b0;
    idle_inputs();
    bus.mem_ready = 1'b1;

    // Rows: set xs xe ys ye | wr pix rdy | we addr data ovf busy
    // window 2..3 x 1..1: cursor wraps back to (2,1)
    vecs.push_back(mk(1,   2,   3,  1,  1, 1, 16'hA0A0, 1, 1,  322, 16'hA0A0, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'hB1B1, 1, 1,  323, 16'hB1B1, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'hC2C2, 1, 1,  322, 16'hC2C2, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 0,    0, 16'h0000, 0, 0));
    // window crossing the right frame edge: x=320,321 discarded silently
    vecs.push_back(mk(1, 318, 321,  0,  0, 1, 16'hD3D3, 1, 1,  318, 16'hD3D3, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'hE4E4, 1, 1,  319, 16'hE4E4, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'hF5F5, 1, 0,    0, 16'h0000, 0, 0));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h0606, 1, 0,    0, 16'h0000, 0, 0));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h1717, 1, 1,  318, 16'h1717, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 0,    0, 16'h0000, 0, 0));
    // stall: out stage + 2 FIFO entries, 4th pixel dropped
    vecs.push_back(mk(1,   0, 319, 10, 10, 1, 16'h2828, 0, 1, 3200, 16'h2828, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h3939, 0, 1, 3200, 16'h2828, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h4A4A, 0, 1, 3200, 16'h2828, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h5B5B, 0, 1, 3200, 16'h2828, 1, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 0, 1, 3200, 16'h2828, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 1, 3201, 16'h3939, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 1, 3202, 16'h4A4A, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 0,    0, 16'h0000, 0, 0));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h6C6C, 1, 1, 3204, 16'h6C6C, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 0,    0, 16'h0000, 0, 0));
    // XS>XE and YS>YE clamp: window collapses to the single point (5,3)
    vecs.push_back(mk(1,   5,   2,  3,  1, 1, 16'h7D7D, 1, 1,  965, 16'h7D7D, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 1, 16'h8E8E, 1, 1,  965, 16'h8E8E, 0, 1));
    vecs.push_back(mk(0,   0,   0,  0,  0, 0, 16'h0000, 1, 0,    0, 16'h0000, 0, 0));

    #3;
    chk("rst_we",   32'(bus.mem_we), 0);
    chk("rst_addr", 32'(bus.mem_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ovf",  32'(overflow), 0);
    #9;
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      waddr_set_req = vecs[i].set;
      col_addr      = {vecs[i].xs, vecs[i].xe};
      row_addr      = {vecs[i].ys, vecs[i].ye};
      write_req     = vecs[i].wr;
      pixel_data    = vecs[i].pix;
      bus.mem_ready = vecs[i].rdy;
      tick();
      chk($sformatf("v%0d_we", i), 32'(bus.mem_we), 32'(vecs[i].we));
      if (vecs[i].we) begin
        chk($sformatf("v%0d_addr", i), 32'(bus.mem_addr), vecs[i].addr);
        chk($sformatf("v%0d_data", i), 32'(bus.mem_wdata), 32'(vecs[i].data));
      end
      chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].bsy));
    end
    idle_inputs();
    bus.mem_ready = 1'b1;

    // Full-frame clear sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    bad = 0;
    first_bad = -1;
    for (int i = 0; i < 76800; i++) begin
      if (!(bus.mem_we === 1'b1 && bus.mem_addr == 17'(i) && bus.mem_wdata == 16'h0000)) begin
        if (bad == 0) first_bad = i;
        bad++;
      end
      tick();
    end
    chk("clr_sweep_bad_beats", 32'(bad), 0);
    if (bad != 0) $display("  first bad sweep beat index %0d", first_bad);
    chk("clr_done_we",   32'(bus.mem_we), 0);
    chk("clr_done_busy", 32'(busy), 0);
    write_req = 1'b1; pixel_data = 16'h1234;
    tick();
    chk("post_clr_addr0", 32'(bus.mem_addr), 0);
    chk("post_clr_data0", 32'(bus.mem_wdata), 32'h1234);
    pixel_data = 16'h5678;
    tick();
    chk("post_clr_addr1", 32'(bus.mem_addr), 1);
    write_req = 1'b0;
    tick();
    chk("post_clr_idle", 32'(bus.mem_we), 0);

    // Write and restart during a sweep
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    chk("mid_clr_addr100", 32'(bus.mem_addr), 100);
    write_req = 1'b1; pixel_data = 16'hBEEF;
    tick();
    write_req = 1'b0;
    chk("mid_clr_ovf",  32'(overflow), 1);
    chk("mid_clr_addr", 32'(bus.mem_addr), 101);
    chk("mid_clr_data", 32'(bus.mem_wdata), 0);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    chk("restart_addr0", 32'(bus.mem_addr), 0);
    chk("restart_ovf",   32'(overflow), 0);
    tick();
    chk("restart_addr1", 32'(bus.mem_addr), 1);
    tick();
    tick();

    // Asynchronous reset in the middle of the sweep
    chk("pre_rst_we", 32'(bus.mem_we), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_we",   32'(bus.mem_we), 0);
    chk("async_rst_busy", 32'(busy), 0);
    tick();
    rst_n = 1'b1;
    write_req = 1'b1; pixel_data = 16'hCAFE;
    tick();
    write_req = 1'b0;
    chk("after_rst_we",   32'(bus.mem_we), 1);
    chk("after_rst_addr", 32'(bus.mem_addr), 0);
    chk("after_rst_data", 32'(bus.mem_wdata), 32'hCAFE);
    tick();
    chk("after_rst_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_wr_ctrl.md
Name: sram_wr_ctrl

Overview:
- Downstream of the SPI command decoder.
- Consumes the decoder's window coordinates, pixel words and request strobes, and turns them into a stream of linear frame-buffer writes toward the SRAM/BRAM port arbiter, using a valid/ready handshake.
- Owns the draw-window cursor, a 2-entry write buffer, and the full-frame clear sweep issued on software reset.

Parameters:
- P_WIDTH, 320, frame width in pixels.
- P_HEIGHT, 240, frame height in pixels.
- P_ADDR_W, 17, memory word address width; must satisfy 2^P_ADDR_W >= P_WIDTH*P_HEIGHT.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_col_addr  in  32  XS in [31:16], XE in [15:0].
- i_row_addr  in  32  YS in [31:16], YE in [15:0].
- i_pixel_data  in  16  RGB565 pixel; valid with i_sram_write_req.
- i_sram_write_req  in  1  1-cycle pulse: push one pixel.
- i_sram_waddr_set_req  in  1  1-cycle pulse: latch window, home cursor.
- i_sram_clr_req  in  1  1-cycle pulse: clear whole frame.
- o_mem_we  out  1  write valid.
- o_mem_addr  out  P_ADDR_W  linear address y*P_WIDTH+x.
- o_mem_wdata  out  16  write data.
- i_mem_ready  in  1  arbiter accepts the write when o_mem_we & i_mem_ready.
- o_busy  out  1  clear in progress, buffer non-empty, or o_mem_we high.
- o_overflow  out  1  1-cycle pulse: a pixel was dropped.

Behaviour:
- Reset (async, i_rst_n=0):
  - All outputs 0; buffer empty; state IDLE.
  - Window XS=0, XE=P_WIDTH-1, YS=0, YE=P_HEIGHT-1; cursor x=0, y=0.
- Window set (i_sram_waddr_set_req=1):
  - Latch XS/XE/YS/YE from the 16-bit fields; set x<=XS, y<=YS.
  - If XS>XE, XE is taken as XS; same rule for YS>YE.
  - Applied before any write_req in the same cycle: that pixel uses the new XS,YS.
- Push (i_sram_write_req=1 in IDLE):
  - Address is computed at push time from the current cursor: addr=y*P_WIDTH+x, truncated to P_ADDR_W.
  - Entry {addr, data} is pushed only if x<P_WIDTH and y<P_HEIGHT. Out-of-frame pixels are silently discarded; they are not counted as overflow.
  - The cursor advances on every request, pushed or discarded: if x==XE then x<=XS and y<=(y==YE)?YS:y+1, otherwise x<=x+1. Wrap from (XE,YE) returns to (XS,YS).
- Buffer:
  - 2-entry FIFO feeding a registered output stage {o_mem_we, o_mem_addr, o_mem_wdata}.
  - Output stage loads from the FIFO head when empty or when the current beat is accepted. Pass-through latency is 1 cycle: a push into an empty FIFO with an idle output gives o_mem_we=1 the next cycle.
  - o_mem_addr/o_mem_wdata are held stable while o_mem_we & ~i_mem_ready.
  - Push to a full FIFO while the output stage is stalled: pixel dropped, o_overflow=1 for 1 cycle, cursor still advances.
  - Simultaneous push and pop with the FIFO full is accepted.
- States:
  - IDLE -> CLEAR on i_sram_clr_req.
  - CLEAR -> IDLE after the write at address P_WIDTH*P_HEIGHT-1 is accepted.
- Clear request (i_sram_clr_req=1, any state):
  - Flush the FIFO and output stage; any pending beat is abandoned.
  - Reset window and cursor to the full-frame values given under Reset.
  - Clear counter <=0.
- CLEAR state:
  - o_mem_we=1, o_mem_addr=counter, o_mem_wdata=16'h0000; the counter increments on each accepted beat.
  - i_sram_clr_req during CLEAR restarts the sweep at 0.
  - i_sram_write_req during CLEAR: pixel dropped, o_overflow pulse, cursor unchanged.
  - i_sram_waddr_set_req during CLEAR: latched normally.
- Clear throughput: P_WIDTH*P_HEIGHT cycles when i_mem_ready is held high.
- o_busy is combinational from state, FIFO count and o_mem_we.

Test Plan:
1. Reset, set window XS=2,XE=3,YS=1,YE=1, 3 pixels A,B,C with i_mem_ready=1 -> writes addr 322/A, 323/B, 322/C, each 1 cycle after its push; o_overflow never asserted.
2. Window XS=318,XE=321,YS=0,YE=0, 4 pixels -> only addr 318 and 319 written; x=320 and x=321 discarded with no overflow; cursor returns to 318.
3. i_mem_ready=0, push 4 pixels back-to-back -> output stage holds the 1st, FIFO holds the 2nd and 3rd, the 4th is dropped with o_overflow=1 for 1 cycle; raise ready -> 3 writes in order with addresses stable during the stall; o_busy falls after the last accept.
4. i_sram_clr_req with ready=1 -> 76800 writes, addr 0..76799, data 0; state returns to IDLE; o_busy=0 the cycle after the final accept; window is full-frame.
5. During CLEAR at counter=100: write_req -> o_overflow pulse, nothing written; then clr_req -> the next accepted address is 0.
6. Assert i_rst_n=0 while o_mem_we=1 mid-clear -> o_mem_we=0 immediately (async); after release, a single pixel goes to addr 0.
